// File: rtl/regfile_multiport.sv
// Parametrised multi-read / multi-write register file with a zero register,
// write-to-read bypass and a hardware clear sweep that runs after reset or on request.
// Optional macro REGFILE_SCOREBOARD_EN adds per-entry pending (reservation) tracking.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
  input  logic [NUM_WRITE-1:0]             wr_en,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]  wr_data,
  input  logic                             clear_req,
  output logic                             busy
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                             rsv_en,
  input  logic [ADDR_WIDTH-1:0]            rsv_addr,
  output logic [NUM_READ-1:0]              rd_pending
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic ZERO_EN   = (ZERO_REG != 0);
  localparam logic BYPASS_EN = (BYPASS != 0);

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE  = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  logic [0:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_rd_addr [NUM_READ];
  logic [DATA_WIDTH-1:0] w_rd_data [NUM_READ];
  logic [NUM_READ-1:0]   w_rd_zero;
  logic [ADDR_WIDTH-1:0] w_wr_addr [NUM_WRITE];
  logic [DATA_WIDTH-1:0] w_wr_data [NUM_WRITE];
  logic [NUM_WRITE-1:0]  w_wr_acc;
  logic                  w_idle;

  assign w_idle = (r_state == ST_IDLE);
  assign busy   = r_busy;

  genvar gi;
  for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
    assign w_rd_addr[gi] = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_rd_zero[gi] = ZERO_EN && (w_rd_addr[gi] == ADDR_ZERO);
    assign rd_data[gi*DATA_WIDTH +: DATA_WIDTH] = w_rd_data[gi];
  end

  for (gi = 0; gi < NUM_WRITE; gi++) begin : g_wr
    assign w_wr_addr[gi] = wr_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wr_data[gi] = wr_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // A write is accepted only in IDLE and never to the hardwired zero entry.
  always_comb begin
    w_wr_acc = {NUM_WRITE{1'b0}};
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (w_idle && wr_en[j] && !(ZERO_EN && (w_wr_addr[j] == ADDR_ZERO))) begin
        w_wr_acc[j] = 1'b1;
      end else begin
        w_wr_acc[j] = 1'b0;
      end
    end
  end

  // Combinational read with forwarding; highest matching write port wins.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      w_rd_data[i] = {DATA_WIDTH{1'b0}};
      if (w_idle && !w_rd_zero[i]) begin
        w_rd_data[i] = r_mem[w_rd_addr[i]];
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (BYPASS_EN && w_wr_acc[j] && (w_wr_addr[j] == w_rd_addr[i])) begin
            w_rd_data[i] = w_wr_data[j];
          end else begin
            w_rd_data[i] = w_rd_data[i];
          end
        end
      end else begin
        w_rd_data[i] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  // Storage: sweep writes zero during CLEAR; later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_cnt] <= {DATA_WIDTH{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_acc[j]) begin
          r_mem[w_wr_addr[j]] <= w_wr_data[j];
        end
      end
    end
  end

  // Clear-sweep control: state, sweep counter and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= ADDR_ZERO;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          if (r_cnt == ADDR_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= ADDR_ZERO;
            r_busy  <= 1'b0;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            r_state <= ST_CLEAR;
            r_cnt   <= ADDR_ZERO;
            r_busy  <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= ADDR_ZERO;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [DEPTH-1:0] r_pend;
  logic [DEPTH-1:0] w_pend_nxt;

  // Pending update: writes clear, a same-cycle reservation re-sets the bit.
  always_comb begin
    w_pend_nxt = r_pend;
    if (!w_idle || clear_req) begin
      w_pend_nxt = {DEPTH{1'b0}};
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_acc[j]) begin
          w_pend_nxt[w_wr_addr[j]] = 1'b0;
        end else begin
          w_pend_nxt = w_pend_nxt;
        end
      end
      if (rsv_en && !(ZERO_EN && (rsv_addr == ADDR_ZERO))) begin
        w_pend_nxt[rsv_addr] = 1'b1;
      end else begin
        w_pend_nxt = w_pend_nxt;
      end
    end
  end

  // Pending bit storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= {DEPTH{1'b0}};
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  for (gi = 0; gi < NUM_READ; gi++) begin : g_pend
    assign rd_pending[gi] = r_pend[w_rd_addr[gi]];
  end
`endif

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: two instances (dual-write with bypass, single-write without)
// checked every cycle against a behavioural model plus directed literal expectations.
module tb_regfile_multiport;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              clear_req;
  logic [NR*AW-1:0]  rd_addr;
  logic [NW-1:0]     wr_en;
  logic [NW*AW-1:0]  wr_addr;
  logic [NW*DW-1:0]  wr_data;
  logic [NR*DW-1:0]  rd_data_a, rd_data_b;
  logic              busy_a, busy_b;
`ifdef REGFILE_SCOREBOARD_EN
  logic              rsv_en;
  logic [AW-1:0]     rsv_addr;
  logic [NR-1:0]     rd_pending_a, rd_pending_b;
`endif

  regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(2),
                      .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_req(clear_req), .busy(busy_a)
`ifdef REGFILE_SCOREBOARD_EN
    , .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pending(rd_pending_a)
`endif
  );

  regfile_multiport #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .NUM_WRITE(1),
                      .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en[0:0]), .wr_addr(wr_addr[AW-1:0]), .wr_data(wr_data[DW-1:0]),
    .clear_req(clear_req), .busy(busy_b)
`ifdef REGFILE_SCOREBOARD_EN
    , .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_pending(rd_pending_b)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;
  bit chk_on   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];
  logic [31:0] pend_a, pend_b;
  int          sweep_left = 32;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_left <= 32;
      pend_a     <= 32'h0;
      pend_b     <= 32'h0;
    end else if (sweep_left > 0) begin
      mem_a[32 - sweep_left] <= 32'h0;
      mem_b[32 - sweep_left] <= 32'h0;
      sweep_left <= sweep_left - 1;
      pend_a     <= 32'h0;
      pend_b     <= 32'h0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (wr_en[j] && wr_addr[j*AW +: AW] != 5'd0) begin
          mem_a[wr_addr[j*AW +: AW]]  <= wr_data[j*DW +: DW];
          pend_a[wr_addr[j*AW +: AW]] <= 1'b0;
          if (j == 0) begin
            mem_b[wr_addr[AW-1:0]]  <= wr_data[DW-1:0];
            pend_b[wr_addr[AW-1:0]] <= 1'b0;
          end
        end
      end
`ifdef REGFILE_SCOREBOARD_EN
      if (rsv_en && rsv_addr != 5'd0) begin
        pend_a[rsv_addr] <= 1'b1;
        pend_b[rsv_addr] <= 1'b1;
      end
`endif
      if (clear_req) begin
        sweep_left <= 32;
        pend_a     <= 32'h0;
        pend_b     <= 32'h0;
      end
    end
  end

  function automatic logic [31:0] exp_rd(input int inst, input logic [4:0] a);
    logic [31:0] r;
    if (sweep_left > 0 || a == 5'd0) return 32'h0;
    if (inst == 1) return mem_b[a];
    r = mem_a[a];
    for (int j = 0; j < 2; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) r = wr_data[j*DW +: DW];
    return r;
  endfunction

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("busy_a", {31'h0, busy_a}, {31'h0, sweep_left > 0});
      chk("busy_b", {31'h0, busy_b}, {31'h0, sweep_left > 0});
      for (int i = 0; i < NR; i++) begin
        chk("rd_a", rd_data_a[i*DW +: DW], exp_rd(0, rd_addr[i*AW +: AW]));
        chk("rd_b", rd_data_b[i*DW +: DW], exp_rd(1, rd_addr[i*AW +: AW]));
`ifdef REGFILE_SCOREBOARD_EN
        chk("pend_a", {31'h0, rd_pending_a[i]}, {31'h0, pend_a[rd_addr[i*AW +: AW]]});
        chk("pend_b", {31'h0, rd_pending_b[i]}, {31'h0, pend_b[rd_addr[i*AW +: AW]]});
`endif
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en     = 2'b00;
    wr_addr   = '0;
    wr_data   = '0;
    clear_req = 1'b0;
`ifdef REGFILE_SCOREBOARD_EN
    rsv_en    = 1'b0;
    rsv_addr  = 5'd0;
`endif
  endtask

  int cyc;

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    chk_on  = 1'b1;
    repeat (2) step();
    chk("reset_busy", {31'h0, busy_a}, 32'h1);
    rst_n = 1'b1;

    cyc = 0;
    while (busy_a && cyc < 100) begin step(); cyc++; end
    chk("sweep_len", 32'(cyc), 32'd32);

    for (int a = 1; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      @(negedge clk);
      chk("swept_zero", rd_data_a[DW-1:0], 32'h0);
      step();
    end

    // write r5, read next cycle on port 1
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'hDEADBEEF};
    step();
    idle_inputs(); rd_addr = {5'd5, 5'd0};
    @(negedge clk);
    chk("r5_a", rd_data_a[2*DW-1:DW], 32'hDEADBEEF);
    chk("r5_b", rd_data_b[2*DW-1:DW], 32'hDEADBEEF);
    step();

    // same-cycle bypass on r7
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h12345678}; rd_addr = {5'd0, 5'd7};
    @(negedge clk);
    chk("byp_on", rd_data_a[DW-1:0], 32'h12345678);
    chk("byp_off", rd_data_b[DW-1:0], 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("r7_after", rd_data_b[DW-1:0], 32'h12345678);
    step();

    // both write ports hit r3
    wr_en = 2'b11; wr_addr = {5'd3, 5'd3}; wr_data = {32'h5555FFFF, 32'hAAAA0000}; rd_addr = {5'd0, 5'd3};
    step();
    idle_inputs();
    @(negedge clk);
    chk("r3_dual", rd_data_a[DW-1:0], 32'h5555FFFF);
    chk("r3_single", rd_data_b[DW-1:0], 32'hAAAA0000);
    step();

    // writes to r0 are dropped and never forwarded
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hFFFFFFFF}; rd_addr = {5'd0, 5'd0};
    @(negedge clk);
    chk("r0_byp", rd_data_a[DW-1:0], 32'h0);
    step();
    idle_inputs();
    @(negedge clk);
    chk("r0_read", rd_data_a[DW-1:0], 32'h0);
    step();

`ifdef REGFILE_SCOREBOARD_EN
    rsv_en = 1'b1; rsv_addr = 5'd4; rd_addr = {5'd0, 5'd4};
    step();
    rsv_en = 1'b0;
    @(negedge clk);
    chk("pend_set", {31'h0, rd_pending_a[0]}, 32'h1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h44};
    step();
    idle_inputs();
    @(negedge clk);
    chk("pend_clr", {31'h0, rd_pending_a[0]}, 32'h0);
    rsv_en = 1'b1; rsv_addr = 5'd4;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'h0, 32'h55};
    step();
    idle_inputs();
    @(negedge clk);
    chk("pend_both", {31'h0, rd_pending_a[0]}, 32'h1);
    step();
`endif

    // clear request with writes and a second clear_req during the sweep
    wr_en = 2'b10; wr_addr = {5'd9, 5'd0}; wr_data = {32'h1, 32'h0};
    step();
    idle_inputs(); rd_addr = {5'd9, 5'd9};
    @(negedge clk);
    chk("r9_set", rd_data_a[DW-1:0], 32'h1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 100) begin
      wr_en = 2'b11; wr_addr = {5'd9, 5'd9}; wr_data = {32'hCAFE0001, 32'hCAFE0000};
      clear_req = (cyc == 10);
      step();
      cyc++;
    end
    idle_inputs();
    chk("clear_len", 32'(cyc), 32'd32);
    @(negedge clk);
    chk("r9_clr_a", rd_data_a[DW-1:0], 32'h0);
    chk("r9_clr_b", rd_data_b[2*DW-1:DW], 32'h0);
    step();

    // asynchronous reset mid-operation raises busy without a clock edge
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h77};
    rst_n = 1'b0;
    #1;
    chk("async_busy", {31'h0, busy_a}, 32'h1);
    idle_inputs();
    step();
    rst_n = 1'b1;
    cyc = 0;
    while (busy_a && cyc < 100) begin step(); cyc++; end
    chk("resweep_len", 32'(cyc), 32'd32);
    rd_addr = {5'd12, 5'd7};
    @(negedge clk);
    chk("r7_reset", rd_data_a[DW-1:0], 32'h0);
    step();

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 50000");
    $fatal(1);
  end

endmodule
